seq_detector_param: RTL

- Parametrised successor to the team's fixed serial-bit sequence detector (clock, reset, x, z).
- Detects a run-time-loadable pattern of PATTERN_WIDTH bits on a serial input qualified by a valid strobe.
- Overlapping or non-overlapping matching is selectable per instance.
- Keeps a saturating match counter, and emits a registered one-cycle pulse z per match.

---
 rtl/seq_detector_param.sv | 84 ++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a run-time loadable pattern, selectable overlap
// handling, a saturating match counter and a registered one-cycle match pulse.
`default_nettype none

module seq_detector_param #(
  parameter int                       PATTERN_WIDTH = 4,
  parameter logic [PATTERN_WIDTH-1:0] RESET_PATTERN = 4'b1001,
  parameter bit                       OVERLAP       = 1'b1,
  parameter int                       COUNT_WIDTH   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     x,
  input  logic                     x_valid,
  input  logic                     load,
  input  logic [PATTERN_WIDTH-1:0] pattern_in,
  input  logic                     clear_count,
  output logic                     z,
  output logic [COUNT_WIDTH-1:0]   match_count,
  output logic [PATTERN_WIDTH-1:0] pattern,
  output logic                     primed
);

  localparam int                       FILL_WIDTH = $clog2(PATTERN_WIDTH + 1);
  localparam logic [FILL_WIDTH-1:0]    FILL_FULL  = FILL_WIDTH'(PATTERN_WIDTH);
  localparam logic [COUNT_WIDTH-1:0]   COUNT_MAX  = '1;

  logic [PATTERN_WIDTH-1:0] history;
  logic [FILL_WIDTH-1:0]    fill;

  logic [PATTERN_WIDTH-1:0] history_shifted;
  logic [FILL_WIDTH-1:0]    fill_inc;
  logic                     match;

  // Candidate state if this edge's bit is accepted; match looks at it directly.
  always_comb begin
    history_shifted = {history[PATTERN_WIDTH-2:0], x};
    fill_inc        = (fill == FILL_FULL) ? fill : fill + 1'b1;
    match           = x_valid && !load && (fill_inc == FILL_FULL)
                      && (history_shifted == pattern);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      history     <= '0;
      fill        <= '0;
      z           <= 1'b0;
      match_count <= '0;
      primed      <= 1'b0;
      pattern     <= RESET_PATTERN;
    end else if (load) begin
      pattern <= pattern_in;
      history <= '0;
      fill    <= '0;
      primed  <= 1'b0;
      z       <= 1'b0;
      if (clear_count) begin
        match_count <= '0;
      end
    end else begin
      z <= match;
      if (x_valid) begin
        if (match && !OVERLAP) begin
          history <= '0;
          fill    <= '0;
          primed  <= 1'b0;
        end else begin
          history <= history_shifted;
          fill    <= fill_inc;
          primed  <= (fill_inc == FILL_FULL);
        end
      end
      // A clear on a match edge still counts that match.
      if (clear_count) begin
        match_count <= match ? COUNT_WIDTH'(1) : '0;
      end else if (match && (match_count != COUNT_MAX)) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
